// File: rtl/store_capture_fifo.sv
// Store capture FIFO between the processor core's store port and a slower consumer.
// Optional running checksum of accepted stores is built when STORE_CHECKSUM_EN is defined.
module store_capture_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          CK,
    input  logic          RESET,
    input  logic          INVALID,
    input  logic [4:0]    INADDR,
    input  logic [31:0]   INDATA,
    input  logic          CPUDONE,
    output logic          OVALID,
    input  logic          OREADY,
    output logic [4:0]    OADDR,
    output logic [31:0]   ODATA,
    output logic [AW:0]   COUNT,
    output logic          OVERFLOW,
    output logic [7:0]    DROPCNT,
    output logic          FLUSHED,
    output logic [31:0]   CHECKSUM
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO   = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);

    logic [36:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          overflow_r;
    logic [7:0]    dropcnt_r;
    logic          flushed_r;
    state_t        state_r;

    logic          nonempty_s;
    logic          push_req_s;
    logic          pop_s;
    logic          accept_s;
    logic          drop_s;

    assign nonempty_s = (count_r != CNT_ZERO);
    assign push_req_s = INVALID && (state_r == ST_RUN);
    assign pop_s      = nonempty_s && OREADY;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign accept_s   = push_req_s && ((count_r != CNT_FULL) || pop_s);
    assign drop_s     = push_req_s && !accept_s;

    // Storage write; contents need no reset because the head is masked while empty.
    always_ff @(posedge CK) begin
        if (!RESET && accept_s) begin
            mem_r[wr_ptr_r] <= {INADDR, INDATA};
        end
    end

    // Pointers, occupancy and overflow bookkeeping.
    always_ff @(posedge CK) begin
        if (RESET) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
            dropcnt_r  <= 8'd0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (accept_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_s && !accept_s) begin
                count_r <= count_r - CNT_ONE;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (dropcnt_r != 8'hFF) begin
                    dropcnt_r <= dropcnt_r + 8'd1;
                end
            end
        end
    end

    // Run/drain/finish sequencing with the registered FLUSHED flag.
    always_ff @(posedge CK) begin
        if (RESET) begin
            state_r   <= ST_RUN;
            flushed_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    flushed_r <= 1'b0;
                    if (CPUDONE) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (count_r == CNT_ZERO) begin
                        state_r   <= ST_FIN;
                        flushed_r <= 1'b1;
                    end else begin
                        flushed_r <= 1'b0;
                    end
                end
                ST_FIN: begin
                    flushed_r <= 1'b1;
                end
                default: begin
                    state_r   <= ST_RUN;
                    flushed_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef STORE_CHECKSUM_EN
    logic [31:0] checksum_r;

    // Running sum over accepted stores only.
    always_ff @(posedge CK) begin
        if (RESET) begin
            checksum_r <= 32'h0;
        end else if (accept_s) begin
            checksum_r <= checksum_r + (INDATA ^ {27'b0, INADDR});
        end
    end

    assign CHECKSUM = checksum_r;
`else
    assign CHECKSUM = 32'h0;
`endif

    assign OVALID   = nonempty_s;
    assign OADDR    = nonempty_s ? mem_r[rd_ptr_r][36:32] : 5'd0;
    assign ODATA    = nonempty_s ? mem_r[rd_ptr_r][31:0]  : 32'h0;
    assign COUNT    = count_r;
    assign OVERFLOW = overflow_r;
    assign DROPCNT  = dropcnt_r;
    assign FLUSHED  = flushed_r;

endmodule

// File: tb/tb_store_capture_fifo.sv
// Self-checking bench for store_capture_fifo against a queue-based reference model.
module tb_store_capture_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_FIN   = 2;

    logic          CK;
    logic          RESET;
    logic          INVALID;
    logic [4:0]    INADDR;
    logic [31:0]   INDATA;
    logic          CPUDONE;
    logic          OVALID;
    logic          OREADY;
    logic [4:0]    OADDR;
    logic [31:0]   ODATA;
    logic [AW:0]   COUNT;
    logic          OVERFLOW;
    logic [7:0]    DROPCNT;
    logic          FLUSHED;
    logic [31:0]   CHECKSUM;

    store_capture_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CK(CK), .RESET(RESET), .INVALID(INVALID), .INADDR(INADDR),
        .INDATA(INDATA), .CPUDONE(CPUDONE), .OVALID(OVALID), .OREADY(OREADY),
        .OADDR(OADDR), .ODATA(ODATA), .COUNT(COUNT), .OVERFLOW(OVERFLOW),
        .DROPCNT(DROPCNT), .FLUSHED(FLUSHED), .CHECKSUM(CHECKSUM)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    int errors = 0;
    int checks = 0;

    // Reference model: the FIFO is just a queue of {addr, data}.
    logic [36:0] mq[$];
    int          mstate;
    int          mdrops;
    bit          movf;
    logic [31:0] mcsum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic inv, input logic [4:0] a,
                              input logic [31:0] d, input logic rdy, input logic dn);
        int  old_size;
        bit  pop;
        if (rst) begin
            mq.delete();
            mstate = M_RUN;
            mdrops = 0;
            movf   = 1'b0;
            mcsum  = 32'h0;
        end else begin
            old_size = mq.size();
            pop = (old_size > 0) && rdy;
            if (pop) void'(mq.pop_front());
            if (inv && mstate == M_RUN) begin
                if (old_size < DEPTH || pop) begin
                    mq.push_back({a, d});
                    mcsum = mcsum + (d ^ {27'b0, a});
                end else begin
                    movf = 1'b1;
                    if (mdrops < 255) mdrops++;
                end
            end
            if (mstate == M_RUN && dn) mstate = M_DRAIN;
            else if (mstate == M_DRAIN && old_size == 0) mstate = M_FIN;
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        exp_addr = 32'h0;
        exp_data = 32'h0;
        if (mq.size() > 0) begin
            exp_addr = {27'b0, mq[0][36:32]};
            exp_data = mq[0][31:0];
        end
        chk("count",    {28'b0, COUNT},    mq.size());
        chk("ovalid",   {31'b0, OVALID},   {31'b0, (mq.size() > 0)});
        chk("oaddr",    {27'b0, OADDR},    exp_addr);
        chk("odata",    ODATA,             exp_data);
        chk("overflow", {31'b0, OVERFLOW}, {31'b0, movf});
        chk("dropcnt",  {24'b0, DROPCNT},  mdrops);
        chk("flushed",  {31'b0, FLUSHED},  {31'b0, (mstate == M_FIN)});
`ifdef STORE_CHECKSUM_EN
        chk("checksum", CHECKSUM, mcsum);
`else
        chk("checksum", CHECKSUM, 32'h0);
`endif
    endtask

    task automatic step(input logic rst, input logic inv, input logic [4:0] a,
                        input logic [31:0] d, input logic rdy, input logic dn);
        @(negedge CK);
        RESET = rst; INVALID = inv; INADDR = a; INDATA = d; OREADY = rdy; CPUDONE = dn;
        @(posedge CK);
        model_edge(rst, inv, a, d, rdy, dn);
        #1;
        check_all();
    endtask

    initial begin
        RESET = 1'b1; INVALID = 1'b0; INADDR = 5'd0; INDATA = 32'h0;
        OREADY = 1'b0; CPUDONE = 1'b0;
        mstate = M_RUN; mdrops = 0; movf = 1'b0; mcsum = 32'h0;

        // Reset with strobes present in the reset cycle.
        step(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("reset_count", {28'b0, COUNT}, 32'd0);

        // Single store, consumer ready.
        step(1'b0, 1'b1, 5'd3, 32'h0000_1234, 1'b1, 1'b0);
        chk("single_addr", {27'b0, OADDR}, 32'd3);
        chk("single_data", ODATA, 32'h0000_1234);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        chk("single_empty", {28'b0, COUNT}, 32'd0);

        // Fill past capacity with consumer stalled.
        for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, 5'(i), 32'(i), 1'b0, 1'b0);
        chk("fill_count", {28'b0, COUNT}, 32'd8);
        chk("fill_ovf", {31'b0, OVERFLOW}, 32'd1);
        chk("fill_drops", {24'b0, DROPCNT}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", ODATA, 32'(i));
            step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        end

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 5'(i + 16), 32'h100 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd31, 32'hAAAA_5555, 1'b1, 1'b0);
        chk("full_pp_count", {28'b0, COUNT}, 32'd8);
        chk("full_pp_drops", {24'b0, DROPCNT}, 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic while running.
        for (int i = 0; i < 300; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                 1'($urandom_range(0, 3) == 0), 1'b0);

        // Drop counter saturation.
        for (int i = 0; i < 270; i++) step(1'b0, 1'b1, 5'($urandom), $urandom, 1'b0, 1'b0);
        chk("drop_sat", {24'b0, DROPCNT}, 32'd255);

        // Checksum sequence from a clean reset.
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd0, 32'h0000_0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd4, 32'h0000_0001, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd8, 32'hFFFF_FFFF, 1'b0, 1'b0);
`ifdef STORE_CHECKSUM_EN
        chk("csum_const", CHECKSUM, 32'hFFFF_FFFC);
`else
        chk("csum_const", CHECKSUM, 32'h0);
`endif

        // Done with two queued entries plus a store on the done edge.
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd1, 32'h11, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1);
        chk("drain_ignored", {28'b0, COUNT}, 32'd3);
        chk("drain_drops", {24'b0, DROPCNT}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1);
        chk("flushed_not_yet", {31'b0, FLUSHED}, 32'd0);
        step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1);
        chk("flushed_rise", {31'b0, FLUSHED}, 32'd1);
        step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1);

        // Done with an empty FIFO, then random activity in the finished state.
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        chk("empty_done_flushed", {31'b0, FLUSHED}, 32'd1);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                 1'($urandom_range(0, 1)), 1'b1);

        // Reset while draining with three entries queued.
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'(i), 32'h500 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        chk("pre_reset_count", {28'b0, COUNT}, 32'd3);
        step(1'b1, 1'b1, 5'd5, 32'h55, 1'b1, 1'b1);
        chk("mid_reset_count", {28'b0, COUNT}, 32'd0);
        chk("mid_reset_flushed", {31'b0, FLUSHED}, 32'd0);
        step(1'b0, 1'b1, 5'd6, 32'h0000_0666, 1'b0, 1'b0);
        chk("post_reset_data", ODATA, 32'h0000_0666);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
